// File: rtl/demux_tdm_serial.sv
// Serial TDM receiver: deserialises an MSB-first bit stream into CHANNELS words and tracks frame lock.
// Optional trailing even-parity bit per frame when TDM_PARITY_CHECK_EN is defined.
module demux_tdm_serial #(
  parameter int CHANNELS   = 4,
  parameter int WORD_WIDTH = 8
) (
  input  logic                           Clock_In,
  input  logic                           Reset_n_In,
  input  logic                           Enable_In,
  input  logic                           Serial_Data_In,
  input  logic                           Frame_Sync_In,
  output logic [CHANNELS*WORD_WIDTH-1:0] Data_Out,
  output logic                           Frame_Valid_Out,
  output logic                           Locked_Out,
  output logic                           Sync_Error_Out
`ifdef TDM_PARITY_CHECK_EN
  ,
  output logic                           Parity_Error_Out
`endif
);

  localparam int DATA_W = CHANNELS * WORD_WIDTH;
`ifdef TDM_PARITY_CHECK_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {HUNT, RECEIVE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   staging;
  logic [DATA_W-1:0]   shifted;

  assign shifted = {staging[DATA_W-2:0], Serial_Data_In};

`ifdef TDM_PARITY_CHECK_EN
  function automatic logic even_parity_ok(input logic [DATA_W-1:0] data, input logic par);
    return ~(^data ^ par);
  endfunction
`endif

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state           <= HUNT;
      cnt             <= '0;
      staging         <= '0;
      Data_Out        <= '0;
      Frame_Valid_Out <= 1'b0;
      Locked_Out      <= 1'b0;
      Sync_Error_Out  <= 1'b0;
`ifdef TDM_PARITY_CHECK_EN
      Parity_Error_Out <= 1'b0;
`endif
    end else begin
      Frame_Valid_Out <= 1'b0;
      Sync_Error_Out  <= 1'b0;
`ifdef TDM_PARITY_CHECK_EN
      Parity_Error_Out <= 1'b0;
`endif
      if (Enable_In) begin
        case (state)
          HUNT: begin
            if (Frame_Sync_In) begin
              staging <= shifted;
              cnt     <= ONE;
              state   <= RECEIVE;
            end
          end
          RECEIVE: begin
            if (Frame_Sync_In && cnt != '0) begin
              // early sync: drop partial frame, this bit opens a new one
              Sync_Error_Out <= 1'b1;
              Locked_Out     <= 1'b0;
              staging        <= shifted;
              cnt            <= ONE;
            end else if (!Frame_Sync_In && cnt == '0) begin
              Sync_Error_Out <= 1'b1;
              Locked_Out     <= 1'b0;
              state          <= HUNT;
            end else if (cnt == LAST) begin
`ifdef TDM_PARITY_CHECK_EN
              // staging already holds every data bit; this edge carries parity only
              if (even_parity_ok(staging, Serial_Data_In)) begin
                Data_Out        <= staging;
                Frame_Valid_Out <= 1'b1;
                Locked_Out      <= 1'b1;
              end else begin
                Parity_Error_Out <= 1'b1;
              end
`else
              staging         <= shifted;
              Data_Out        <= shifted;
              Frame_Valid_Out <= 1'b1;
              Locked_Out      <= 1'b1;
`endif
              cnt <= '0;
            end else begin
              staging <= shifted;
              cnt     <= cnt + ONE;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux_tdm_serial.sv
// Scoreboard bench for demux_tdm_serial: a frame-level model queues expected strobes, a monitor matches them.
module tb_demux_tdm_serial;

  localparam int CH = 4;
  localparam int WW = 8;
  localparam int NB = CH * WW;
`ifdef TDM_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          din = 1'b0;
  logic          fsync = 1'b0;
  logic [NB-1:0] dout;
  logic          fvalid, locked, serr, perr;

  demux_tdm_serial #(.CHANNELS(CH), .WORD_WIDTH(WW)) dut (
    .Clock_In        (clk),
    .Reset_n_In      (rst_n),
    .Enable_In       (en),
    .Serial_Data_In  (din),
    .Frame_Sync_In   (fsync),
    .Data_Out        (dout),
    .Frame_Valid_Out (fvalid),
    .Locked_Out      (locked),
    .Sync_Error_Out  (serr)
`ifdef TDM_PARITY_CHECK_EN
    ,
    .Parity_Error_Out(perr)
`endif
  );
`ifndef TDM_PARITY_CHECK_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // kind: 0 = frame published, 1 = sync error, 2 = parity error
  typedef struct {
    int            kind;
    logic [NB-1:0] data;
    int            cyc;
    bit            lock;
  } ev_t;
  ev_t q[$];

  // Frame-level reference: position within the current frame plus word accumulated so far
  bit            m_hunt = 1'b1;
  int            m_pos = 0;
  logic [NB-1:0] m_word = '0;
  logic [NB-1:0] m_last = '0;
  bit            m_lock = 1'b0;

  function automatic void push(input int kind);
    ev_t e;
    e.kind = kind; e.data = m_last; e.cyc = cyc + 1; e.lock = m_lock;
    q.push_back(e);
  endfunction

  function automatic void model(input logic b, input logic s);
    if (m_hunt) begin
      if (s) begin m_hunt = 1'b0; m_word = NB'(b); m_pos = 1; end
    end else if (s && m_pos != 0) begin
      m_lock = 1'b0; push(1); m_word = NB'(b); m_pos = 1;
    end else if (!s && m_pos == 0) begin
      m_lock = 1'b0; push(1); m_hunt = 1'b1;
    end else if (PAR && m_pos == NB) begin
      if ((($countones(m_word) + int'(b)) % 2) == 0) begin
        m_last = m_word; m_lock = 1'b1; push(0);
      end else push(2);
      m_pos = 0;
    end else begin
      m_word = m_word * 2 + NB'(b);
      m_pos++;
      if (m_pos == NB && !PAR) begin
        m_last = m_word; m_lock = 1'b1; push(0); m_pos = 0;
      end
    end
  endfunction

  task automatic drive(input logic b, input logic s, input logic e);
    @(negedge clk);
    en = e; din = b; fsync = s;
    if (e) model(b, s);
  endtask

  task automatic send_bits(input logic [NB-1:0] w, input int n, input int stall_at, input int stall_len);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at)
        for (int k = 0; k < stall_len; k++) drive(1'($urandom), 1'($urandom), 1'b0);
      drive(w[NB-1-i], i == 0, 1'b1);
    end
  endtask

  task automatic send_frame(input logic [NB-1:0] w, input int stall_at, input logic bad_par);
    send_bits(w, NB, stall_at, 5);
    if (PAR) drive(^w ^ bad_par, 1'b0, 1'b1);
  endtask

  // Monitor: every strobe must match the oldest queued event, on the predicted cycle
  int   kind_seen;
  ev_t  ev;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fvalid || serr || perr) begin
        chk("single_strobe", 64'(int'(fvalid) + int'(serr) + int'(perr)), 64'd1);
        kind_seen = fvalid ? 0 : (serr ? 1 : 2);
        if (q.size() == 0) chk("unexpected_strobe", 64'(kind_seen), 64'hff);
        else begin
          ev = q.pop_front();
          chk("strobe_kind", 64'(kind_seen), 64'(ev.kind));
          chk("strobe_cycle", 64'(cyc), 64'(ev.cyc));
          chk("data_out", 64'(dout), 64'(ev.data));
          chk("locked", 64'(locked), 64'(ev.lock));
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missing_strobe_kind", 64'hff, 64'(q[0].kind));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] w;
    repeat (3) @(negedge clk);
    chk("reset_data", 64'(dout), 64'd0);
    chk("reset_valid", 64'(fvalid), 64'd0);
    chk("reset_locked", 64'(locked), 64'd0);
    chk("reset_serr", 64'(serr), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // 1: back-to-back frames
    send_frame(32'hA53CFF00, -1, 1'b0);
    send_frame(32'h01020480, -1, 1'b0);
    chk("t1_frame1", 64'(dout), 64'hA53CFF00);
    chk("t1_locked", 64'(locked), 64'd1);
    send_frame(32'h01020480, -1, 1'b0);
    chk("t1_frame2", 64'(dout), 64'h01020480);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t1_frame3", 64'(dout), 64'h01020480);

    // 2: 5-cycle stall in mid slot 2
    send_frame(32'hDEADBEEF, 20, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t2_data", 64'(dout), 64'hDEADBEEF);

    // 3: early sync at bit 13 of a locked stream, then full frame from there
    send_bits(32'h12345678, 13, -1, 0);
    send_frame(32'hCAFEF00D, -1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t3_data", 64'(dout), 64'hCAFEF00D);

    // 4: missing sync at frame start, hunt over junk, then resync
    send_frame(32'h0F0F0F0F, -1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'($urandom), 1'b0, 1'b1);
    send_frame(32'h76543210, -1, 1'b0);

    // 5: asynchronous reset mid-cycle at bit 20
    send_bits(32'hFFFFFFFF, 20, -1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_data", 64'(dout), 64'd0);
    chk("t5_locked", 64'(locked), 64'd0);
    chk("t5_valid", 64'(fvalid), 64'd0);
    q.delete();
    m_hunt = 1'b1; m_pos = 0; m_word = '0; m_last = '0; m_lock = 1'b0;
    @(negedge clk);
    en = 1'b0; rst_n = 1'b1;
    send_frame(32'h89ABCDEF, -1, 1'b0);

`ifdef TDM_PARITY_CHECK_EN
    // 6: wrong parity rejected, then the same frame with correct parity
    send_frame(32'hA53CFF00, -1, 1'b1);
    send_frame(32'hA53CFF00, -1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("t6_data", 64'(dout), 64'hA53CFF00);
`endif

    // Random frames with occasional stalls, aborted frames and (with parity) bad parity bits
    for (int f = 0; f < 40; f++) begin
      w = NB'($urandom);
      if ($urandom_range(0, 7) == 0)
        send_bits(NB'($urandom), $urandom_range(1, NB - 1), -1, 0);
      send_frame(w, ($urandom_range(0, 2) == 0) ? $urandom_range(0, NB - 1) : -1,
                 1'($urandom_range(0, 5) == 0));
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    chk("final_data", 64'(dout), 64'(m_last));
    chk("final_locked", 64'(locked), 64'(m_lock));
    chk("pending_events", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
